// File: rtl/lb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : lb_arb2
// Brief    : Two-master local-bus arbiter. The host (network bridge) always
//            wins and is never stalled; a secondary sequencer issues through a
//            req/ack handshake in free cycles. Pipelined read data is routed
//            back to its issuer through an owner-tag delay line.
// Revision : 1.0 - initial release
// ============================================================================
module lb_arb2 #(
    parameter int AW         = 24,
    parameter int READ_DELAY = 3,
    parameter int WAIT_W     = 16
) (
    input  logic              lb_clk,
    input  logic              rst,
    // host master
    input  logic              h_strobe,
    input  logic              h_rd,
    input  logic [AW-1:0]     h_addr,
    input  logic [31:0]       h_wdata,
    output logic [31:0]       h_rdata,
    output logic              h_rvalid,
    // secondary master
    input  logic              s_req,
    input  logic              s_rd,
    input  logic [AW-1:0]     s_addr,
    input  logic [31:0]       s_wdata,
    output logic              s_ack,
    output logic [31:0]       s_rdata,
    output logic              s_rvalid,
    // shared application bus
    output logic              m_strobe,
    output logic              m_rd,
    output logic [AW-1:0]     m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    // diagnostics
    output logic [WAIT_W-1:0] s_wait
);

    localparam logic [WAIT_W-1:0] c_WAIT_MAX = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] c_WAIT_ONE = WAIT_W'(1);

    logic                  w_sec_issue;
    logic                  w_issue;
    logic                  w_nxt_rd;
    logic [AW-1:0]         w_nxt_addr;
    logic [31:0]           w_nxt_wdata;
    logic                  w_starve;
    logic                  w_ret_h;
    logic                  w_ret_s;

    logic                  r_m_strobe;
    logic                  r_m_rd;
    logic [AW-1:0]         r_m_addr;
    logic [31:0]           r_m_wdata;
    logic                  r_s_ack;
    // bit 0 lines up with m_strobe; bit READ_DELAY lines up with m_rdata
    logic [READ_DELAY:0]   r_tag_v;
    logic [READ_DELAY:0]   r_tag_o;
    logic                  r_h_rvalid;
    logic [31:0]           r_h_rdata;
    logic                  r_s_rvalid;
    logic [31:0]           r_s_rdata;
    logic [WAIT_W-1:0]     r_s_wait;

    // Issue decision: host first; secondary only when the bus is free and its
    // previous request has not just been acked (blocks a double issue).
    always_comb begin
        w_sec_issue = !h_strobe && s_req && !r_s_ack;
        w_issue     = h_strobe || w_sec_issue;
        w_nxt_rd    = h_rd;
        w_nxt_addr  = h_addr;
        w_nxt_wdata = h_wdata;
        if (!h_strobe) begin
            w_nxt_rd    = s_rd;
            w_nxt_addr  = s_addr;
            w_nxt_wdata = s_wdata;
        end
        w_starve = s_req && h_strobe && !r_s_ack;
        w_ret_h  = r_tag_v[READ_DELAY] && !r_tag_o[READ_DELAY];
        w_ret_s  = r_tag_v[READ_DELAY] &&  r_tag_o[READ_DELAY];
    end

    // Shared-bus command register; address/data hold when nothing issues.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            r_m_strobe <= 1'b0;
            r_m_rd     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_s_ack    <= 1'b0;
        end else begin
            r_m_strobe <= w_issue;
            r_s_ack    <= w_sec_issue;
            if (w_issue) begin
                r_m_rd    <= w_nxt_rd;
                r_m_addr  <= w_nxt_addr;
                r_m_wdata <= w_nxt_wdata;
            end
        end
    end

    // Owner-tag delay line: {read valid, owner} travels alongside the access.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            r_tag_v <= '0;
            r_tag_o <= '0;
        end else begin
            r_tag_v <= {r_tag_v[READ_DELAY-1:0], w_issue && w_nxt_rd};
            r_tag_o <= {r_tag_o[READ_DELAY-1:0], w_sec_issue};
        end
    end

    // Read return: capture m_rdata into the owning master's data register.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            r_h_rvalid <= 1'b0;
            r_h_rdata  <= '0;
            r_s_rvalid <= 1'b0;
            r_s_rdata  <= '0;
        end else begin
            r_h_rvalid <= w_ret_h;
            r_s_rvalid <= w_ret_s;
            if (w_ret_h) begin
                r_h_rdata <= m_rdata;
            end
            if (w_ret_s) begin
                r_s_rdata <= m_rdata;
            end
        end
    end

    // Starvation counter: cycles the secondary was denied by the host, saturating.
    always_ff @(posedge lb_clk) begin
        if (rst) begin
            r_s_wait <= '0;
        end else if (w_starve && (r_s_wait != c_WAIT_MAX)) begin
            r_s_wait <= r_s_wait + c_WAIT_ONE;
        end
    end

    assign m_strobe = r_m_strobe;
    assign m_rd     = r_m_rd;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;
    assign s_ack    = r_s_ack;
    assign h_rvalid = r_h_rvalid;
    assign h_rdata  = r_h_rdata;
    assign s_rvalid = r_s_rvalid;
    assign s_rdata  = r_s_rdata;
    assign s_wait   = r_s_wait;

endmodule
`default_nettype wire

// File: tb/tb_lb_arb2.sv
`default_nettype none
// ============================================================================
// Module   : tb_lb_arb2
// Brief    : Self-checking bench for lb_arb2: directed sequences, a small
//            table of host reads and a randomized run against a queue-based
//            reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lb_arb2;

    localparam int AW   = 24;
    localparam int RD   = 3;
    localparam int WW   = 4;
    localparam int WMAX = (1 << WW) - 1;

    logic          lb_clk;
    logic          rst;
    logic          h_strobe, h_rd;
    logic [AW-1:0] h_addr;
    logic [31:0]   h_wdata;
    logic [31:0]   h_rdata;
    logic          h_rvalid;
    logic          s_req, s_rd;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_wdata;
    logic          s_ack;
    logic [31:0]   s_rdata;
    logic          s_rvalid;
    logic          m_strobe, m_rd;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic [31:0]   m_rdata;
    logic [WW-1:0] s_wait;

    lb_arb2 #(.AW(AW), .READ_DELAY(RD), .WAIT_W(WW)) dut (
        .lb_clk  (lb_clk),
        .rst     (rst),
        .h_strobe(h_strobe),
        .h_rd    (h_rd),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_rdata (h_rdata),
        .h_rvalid(h_rvalid),
        .s_req   (s_req),
        .s_rd    (s_rd),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_ack   (s_ack),
        .s_rdata (s_rdata),
        .s_rvalid(s_rvalid),
        .m_strobe(m_strobe),
        .m_rd    (m_rd),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .s_wait  (s_wait)
    );

    initial lb_clk = 1'b0;
    always #5 lb_clk = ~lb_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // application-side memory: read data appears exactly RD cycles after strobe
    logic          pv [0:RD];
    logic [AW-1:0] pa [0:RD];

    // reference model state (expected outputs for the current cycle)
    typedef struct { int due; logic own; logic [31:0] data; } ret_t;
    ret_t          ret_q[$];
    logic          e_strobe, e_rd, e_sack, e_hv, e_sv;
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wdata, e_hd, e_sd;
    int            e_wait;

    typedef struct { logic [AW-1:0] addr; logic [31:0] exp; } rdvec_t;
    rdvec_t tbl [4];

    function automatic logic [31:0] mem_f(input logic [AW-1:0] a);
        return 32'hCAFE0000 ^ {8'h00, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        e_strobe = 1'b0; e_rd = 1'b0; e_addr = '0; e_wdata = '0; e_sack = 1'b0;
        e_wait = 0; e_hv = 1'b0; e_hd = '0; e_sv = 1'b0; e_sd = '0;
        ret_q.delete();
    endtask

    task automatic check_outputs();
        chk("m_strobe", m_strobe, e_strobe);
        chk("m_rd",     m_rd,     e_rd);
        chk("m_addr",   m_addr,   e_addr);
        chk("m_wdata",  m_wdata,  e_wdata);
        chk("s_ack",    s_ack,    e_sack);
        chk("s_wait",   s_wait,   e_wait);
        chk("h_rvalid", h_rvalid, e_hv);
        chk("h_rdata",  h_rdata,  e_hd);
        chk("s_rvalid", s_rvalid, e_sv);
        chk("s_rdata",  s_rdata,  e_sd);
    endtask

    // Advance the reference model with this cycle's inputs.
    task automatic model_advance();
        logic host, sec;
        ret_t r;
        if (rst) begin
            model_reset();
        end else begin
            host = h_strobe;
            sec  = !h_strobe && s_req && !e_sack;
            if (s_req && h_strobe && !e_sack && e_wait < WMAX) e_wait++;
            e_strobe = host || sec;
            e_sack   = sec;
            if (host) begin
                e_rd = h_rd; e_addr = h_addr; e_wdata = h_wdata;
            end else if (sec) begin
                e_rd = s_rd; e_addr = s_addr; e_wdata = s_wdata;
            end
            if ((host && h_rd) || (sec && s_rd))
                ret_q.push_back('{cyc + RD + 2, sec, mem_f(host ? h_addr : s_addr)});
            e_hv = 1'b0;
            e_sv = 1'b0;
            if (ret_q.size() > 0 && ret_q[0].due == cyc + 1) begin
                r = ret_q.pop_front();
                if (r.own) begin e_sv = 1'b1; e_sd = r.data; end
                else       begin e_hv = 1'b1; e_hd = r.data; end
            end
        end
        cyc++;
    endtask

    // One bus cycle: memory responds, outputs are checked, model steps.
    task automatic tick();
        @(negedge lb_clk);
        for (int i = RD; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = m_strobe && m_rd;
        pa[0] = m_addr;
        m_rdata = pv[RD] ? mem_f(pa[RD]) : {16'hBAD0, 16'($urandom)};
        check_outputs();
        model_advance();
        @(posedge lb_clk);
        #1;
    endtask

    task automatic idle_in();
        h_strobe = 1'b0;
        s_req    = 1'b0;
        rst      = 1'b0;
    endtask

    initial begin
        tbl[0] = '{24'h000020, 32'hCAFE0020};
        tbl[1] = '{24'h000123, 32'hCAFE0123};
        tbl[2] = '{24'hFFFFFF, 32'hCA01FFFF};
        tbl[3] = '{24'h5A5A5A, 32'hCAA45A5A};

        rst = 1'b1; h_strobe = 0; h_rd = 0; h_addr = '0; h_wdata = '0;
        s_req = 0; s_rd = 0; s_addr = '0; s_wdata = '0; m_rdata = '0;
        for (int i = 0; i <= RD; i++) begin pv[i] = 1'b0; pa[i] = '0; end
        repeat (2) @(posedge lb_clk);
        #1;
        model_reset();
        tick();
        idle_in();
        tick();

        // host-only write burst
        for (int i = 0; i < 4; i++) begin
            h_strobe = 1; h_rd = 0; h_addr = AW'(32'h10 + i); h_wdata = 32'hA5000000 + i;
            tick();
            chk("t1_strobe", m_strobe, 1);
            chk("t1_addr",   m_addr,   32'h10 + i);
            chk("t1_wdata",  m_wdata,  32'hA5000000 + i);
        end
        idle_in();
        tick();
        chk("t1_idle", m_strobe, 0);
        chk("t1_hold", m_addr, 24'h13);
        for (int k = 0; k < 6; k++) begin
            chk("t1_no_hrv", h_rvalid, 0);
            chk("t1_no_srv", s_rvalid, 0);
            tick();
        end

        // table of host reads: rvalid exactly RD+2 cycles after h_strobe
        for (int v = 0; v < 4; v++) begin
            h_strobe = 1; h_rd = 1; h_addr = tbl[v].addr;
            tick();
            idle_in();
            for (int k = 1; k <= 6; k++) begin
                chk("t2_hrvalid", h_rvalid, (k == 5));
                chk("t2_srvalid", s_rvalid, 0);
                if (k >= 5) chk("t2_hrdata", h_rdata, tbl[v].exp);
                tick();
            end
        end

        // secondary held off by a 6-cycle host burst
        s_req = 1; s_rd = 1; s_addr = 24'h30; s_wdata = '0;
        for (int k = 0; k < 6; k++) begin
            h_strobe = 1; h_rd = 0; h_addr = AW'(32'h100 + k); h_wdata = k;
            tick();
            chk("t3_no_ack", s_ack, 0);
        end
        h_strobe = 0;
        tick();
        chk("t3_ack", s_ack, 1);
        chk("t3_wait", s_wait, 6);
        chk("t3_addr", m_addr, 24'h30);
        s_req = 0;
        tick();
        chk("t3_ack_pulse", s_ack, 0);
        for (int k = 8; k <= 12; k++) begin
            chk("t3_srvalid", s_rvalid, (k == 11));
            chk("t3_no_hrv", h_rvalid, 0);
            if (k == 11) chk("t3_srdata", s_rdata, 32'hCAFE0030);
            tick();
        end

        // interleaved host/secondary/host reads
        h_strobe = 1; h_rd = 1; h_addr = 24'h40;
        tick();
        h_strobe = 0; s_req = 1; s_rd = 1; s_addr = 24'h50;
        tick();
        chk("t4_ack", s_ack, 1);
        s_req = 0; h_strobe = 1; h_rd = 1; h_addr = 24'h41;
        tick();
        idle_in();
        for (int k = 3; k <= 8; k++) begin
            chk("t4_hrvalid", h_rvalid, (k == 5 || k == 7));
            chk("t4_srvalid", s_rvalid, (k == 6));
            if (k == 5) chk("t4_hrdata0", h_rdata, 32'hCAFE0040);
            if (k == 6) chk("t4_srdata",  s_rdata, 32'hCAFE0050);
            if (k == 7) chk("t4_hrdata1", h_rdata, 32'hCAFE0041);
            tick();
        end

        // starvation counter saturation (counter already at 6)
        s_req = 1; s_rd = 0; s_addr = 24'h60; s_wdata = 32'h600D;
        for (int k = 1; k <= 20; k++) begin
            h_strobe = 1; h_rd = 0; h_addr = AW'(32'h200 + k);
            tick();
            if (k == 8)  chk("t5_wait14", s_wait, 14);
            if (k == 9)  chk("t5_wait15", s_wait, 15);
            if (k == 20) chk("t5_sat",    s_wait, 15);
        end
        h_strobe = 0;
        tick();
        chk("t5_ack", s_ack, 1);
        s_req = 0;
        tick();

        // reset in the middle of a secondary read
        tick();
        s_req = 1; s_rd = 1; s_addr = 24'h70;
        tick();
        chk("t6_ack", s_ack, 1);
        tick();
        chk("t6_ack_pre_rst", s_ack, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("t6_m_strobe", m_strobe, 0);
        chk("t6_m_rd",     m_rd,     0);
        chk("t6_m_addr",   m_addr,   0);
        chk("t6_m_wdata",  m_wdata,  0);
        chk("t6_s_ack",    s_ack,    0);
        chk("t6_s_wait",   s_wait,   0);
        chk("t6_h_rvalid", h_rvalid, 0);
        chk("t6_h_rdata",  h_rdata,  0);
        chk("t6_s_rvalid", s_rvalid, 0);
        chk("t6_s_rdata",  s_rdata,  0);
        tick();
        chk("t6_ack_after", s_ack, 1);
        s_req = 0;
        for (int k = 4; k <= 9; k++) begin
            chk("t6_srvalid", s_rvalid, (k == 8));
            chk("t6_no_hrv", h_rvalid, 0);
            if (k == 8) chk("t6_srdata", s_rdata, 32'hCAFE0070);
            tick();
        end

        // randomized traffic against the reference model
        for (int n = 0; n < 1500; n++) begin
            h_strobe = ($urandom_range(0, 1) == 1);
            h_rd     = ($urandom_range(0, 1) == 1);
            h_addr   = AW'($urandom);
            h_wdata  = $urandom;
            rst      = ($urandom_range(0, 99) == 0);
            if (s_ack) s_req = 0;
            if (!s_req && $urandom_range(0, 2) == 0) begin
                s_req   = 1;
                s_rd    = ($urandom_range(0, 1) == 1);
                s_addr  = AW'($urandom);
                s_wdata = $urandom;
            end
            tick();
        end
        idle_in();
        repeat (RD + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lb_arb2.md
Name: lb_arb2

Overview:
- Shares the single application local bus between two masters.
- Host master: the network-link bridge. It has fixed latency and is never stalled.
- Secondary master: an on-chip sequencer, e.g. a Zest peripheral init/config script engine, using a req/ack handshake.
- Sits between the bridge and application_top, in the lb_clk domain. Routes pipelined read data back to the issuing master with an owner-tag delay line.

Parameters:
- AW, 24, address width.
- READ_DELAY, 3, cycles from m_strobe high until m_rdata is valid at the application side (>=1).
- WAIT_W, 16, width of the secondary-starvation counter.

Ports:
- lb_clk  input  1  local-bus clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- h_strobe  input  1  host transaction strobe (1 cycle per access).
- h_rd  input  1  host read (1) / write (0); valid with h_strobe.
- h_addr  input  AW  host address.
- h_wdata  input  32  host write data.
- h_rdata  output  32  host read data.
- h_rvalid  output  1  1-cycle pulse; h_rdata valid.
- s_req  input  1  secondary request, level; held with s_rd/s_addr/s_wdata stable until s_ack.
- s_rd  input  1  secondary read/write select.
- s_addr  input  AW  secondary address.
- s_wdata  input  32  secondary write data.
- s_ack  output  1  1-cycle pulse; secondary access issued.
- s_rdata  output  32  secondary read data.
- s_rvalid  output  1  1-cycle pulse; s_rdata valid.
- m_strobe  output  1  shared-bus strobe.
- m_rd  output  1  shared-bus read select.
- m_addr  output  AW  shared-bus address.
- m_wdata  output  32  shared-bus write data.
- m_rdata  input  32  shared-bus read data.
- s_wait  output  WAIT_W  saturating count of cycles s_req was denied.

Behaviour:
- All outputs are registered.
- Reset values: m_strobe=0, m_rd=0, m_addr=0, m_wdata=0, h_rvalid=0, s_rvalid=0, s_ack=0, h_rdata=0, s_rdata=0, s_wait=0.
- Issue rule, evaluated each cycle:
  - If h_strobe=1: host wins. Next cycle m_strobe=1 with m_rd/m_addr/m_wdata=h_*. Host latency h_strobe->m_strobe is exactly 1 cycle, always.
  - Else if s_req=1 and s_ack=0: secondary issues. Next cycle m_strobe=1 with m_*=s_*, and s_ack=1 in that same cycle. The s_ack=0 qualifier blocks a double issue while the requester drops s_req.
  - Else: m_strobe=0. m_rd/m_addr/m_wdata hold their previous values.
- Secondary throughput: at most one access per 2 cycles.
- Host throughput: any rate, back-to-back allowed.
- Owner tag pipeline:
  - On each issue, shift {valid=m_rd-to-be, owner(0=host,1=sec)} into a READ_DELAY-deep delay line aligned with m_strobe.
  - At the cycle READ_DELAY after an m_strobe whose tag is a read, capture m_rdata. The next cycle, drive h_rdata/h_rvalid (owner 0) or s_rdata/s_rvalid (owner 1).
  - Total host read latency, h_strobe to h_rvalid: READ_DELAY+2 cycles, constant.
  - Write issues shift in valid=0 and produce no rvalid.
- Reads from both owners may be in flight simultaneously. Each returns in issue order with no loss, even back to back.
- h_rdata/s_rdata hold their last value when the matching rvalid is 0.
- Starvation counter: s_wait increments each cycle with s_req=1, h_strobe=1 and s_ack=0. It saturates at 2^WAIT_W-1 and never wraps. It clears only on rst.
- Reset mid-operation:
  - Tag pipeline is cleared; in-flight reads produce no rvalid.
  - A pending s_req is not acked until the first cycle after rst deasserts.
  - rst has priority over every event in the same cycle.
- Host and secondary strobing in the same cycle: host issues; secondary retries on the next free cycle with the same request.

Test Plan:
- Host-only writes: h_strobe on 4 consecutive cycles, addrs 0x10..0x13 -> m_strobe high on 4 consecutive cycles starting 1 cycle later, matching addr/data; no rvalid pulses.
- Host read, READ_DELAY=3: h_strobe, h_rd=1, addr 0x20; model returns 0xCAFE0020 -> h_rvalid exactly 5 cycles after h_strobe with h_rdata=0xCAFE0020; s_rvalid stays 0.
- Secondary contention: s_req held with read of 0x30 while h_strobe runs 6 consecutive cycles -> no s_ack during the burst; s_ack on the cycle after burst end+1; s_wait=6; s_rdata matches the model for 0x30.
- Interleaved reads: host read 0x40, then secondary read 0x50 in the next cycle, then host read 0x41 -> rvalids occur in order h,s,h with data for 0x40, 0x50, 0x41; no cross-routing.
- Saturation: WAIT_W=4, host strobing continuously for 20 cycles with s_req=1 -> s_wait stops at 15.
- Reset mid-read: issue a secondary read, assert rst 1 cycle later for 1 cycle -> no s_rvalid and no h_rvalid; all outputs at reset values; s_ack is 0 during rst and, with s_req still high, pulses in the first cycle after rst deasserts.
